// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch / data) arbiter in front of one shared memory,
//            alternating on conflict, with a wait-cycle timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,

    input  logic                  dm_req,
    input  logic                  dm_rw,
    input  logic [3:0]            dm_select,
    input  logic [DATA_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,

    output logic                  mem_access,
    output logic                  mem_rw,
    output logic [3:0]            mem_select,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,

    output logic                  if_stall,
    output logic                  mem_stall,
    output logic                  bus_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT_I = 2'd1;
    localparam logic [1:0] c_GRANT_D = 2'd2;
    // Counter value in the last permitted wait cycle of a grant.
    localparam logic [7:0] c_WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_last_d;
    logic                  w_last_d_next;
    logic [7:0]            r_wait_cnt;
    logic [7:0]            w_wait_cnt_next;

    logic                  r_if_ready,   w_if_ready_next;
    logic                  r_dm_ready,   w_dm_ready_next;
    logic                  r_bus_err,    w_bus_err_next;
    logic [DATA_WIDTH-1:0] r_if_rdata,   w_if_rdata_next;
    logic [DATA_WIDTH-1:0] r_dm_rdata,   w_dm_rdata_next;
    logic                  r_mem_access, w_mem_access_next;
    logic                  r_mem_rw,     w_mem_rw_next;
    logic [3:0]            r_mem_select, w_mem_select_next;
    logic [DATA_WIDTH-1:0] r_mem_addr,   w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_wdata,  w_mem_wdata_next;

    logic w_in_grant;
    logic w_timeout;
    logic w_done;
    logic w_pick_d;
    logic w_pick_i;

    assign w_in_grant = (r_state == c_GRANT_I) || (r_state == c_GRANT_D);
    assign w_timeout  = w_in_grant && !mem_ready && (r_wait_cnt == c_WAIT_LIMIT);
    assign w_done     = w_in_grant && (mem_ready || w_timeout);

    // On conflict the side that did not win last time gets the memory.
    assign w_pick_d = dm_req && (!if_req || !r_last_d);
    assign w_pick_i = if_req && !w_pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_last_d     <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
            r_bus_err    <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_mem_access <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_select <= 4'h0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_d     <= w_last_d_next;
            r_wait_cnt   <= w_wait_cnt_next;
            r_if_ready   <= w_if_ready_next;
            r_dm_ready   <= w_dm_ready_next;
            r_bus_err    <= w_bus_err_next;
            r_if_rdata   <= w_if_rdata_next;
            r_dm_rdata   <= w_dm_rdata_next;
            r_mem_access <= w_mem_access_next;
            r_mem_rw     <= w_mem_rw_next;
            r_mem_select <= w_mem_select_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_pick_d) begin
                    w_state_next = c_GRANT_D;
                end else if (w_pick_i) begin
                    w_state_next = c_GRANT_I;
                end
            end
            c_GRANT_I, c_GRANT_D: begin
                if (w_done) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_mem_access_next = (w_state_next != c_IDLE);
        w_mem_rw_next     = r_mem_rw;
        w_mem_select_next = r_mem_select;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_if_ready_next   = 1'b0;
        w_dm_ready_next   = 1'b0;
        w_bus_err_next    = w_timeout;
        w_if_rdata_next   = r_if_rdata;
        w_dm_rdata_next   = r_dm_rdata;
        w_wait_cnt_next   = r_wait_cnt;
        w_last_d_next     = r_last_d;

        if (r_state == c_IDLE) begin
            w_wait_cnt_next = 8'd0;
            if (w_pick_d) begin
                w_mem_rw_next     = dm_rw;
                w_mem_select_next = dm_select;
                w_mem_addr_next   = dm_addr;
                w_mem_wdata_next  = dm_wdata;
            end else if (w_pick_i) begin
                w_mem_rw_next     = 1'b0;
                w_mem_select_next = 4'hF;
                w_mem_addr_next   = if_addr;
                w_mem_wdata_next  = '0;
            end
        end else if (w_in_grant) begin
            if (!mem_ready) begin
                w_wait_cnt_next = r_wait_cnt + 8'd1;
            end
            // An aborted transfer still completes towards the requester, with zero data.
            if (w_done) begin
                if (r_state == c_GRANT_I) begin
                    w_if_ready_next = 1'b1;
                    w_if_rdata_next = mem_ready ? mem_rdata : '0;
                    w_last_d_next   = 1'b0;
                end else begin
                    w_dm_ready_next = 1'b1;
                    w_dm_rdata_next = mem_ready ? mem_rdata : '0;
                    w_last_d_next   = 1'b1;
                end
            end
        end
    end

    assign if_ready   = r_if_ready;
    assign dm_ready   = r_dm_ready;
    assign bus_err    = r_bus_err;
    assign if_rdata   = r_if_rdata;
    assign dm_rdata   = r_dm_rdata;
    assign mem_access = r_mem_access;
    assign mem_rw     = r_mem_rw;
    assign mem_select = r_mem_select;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    assign if_stall  = if_req & ~r_if_ready;
    assign mem_stall = dm_req & ~r_dm_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized scoreboard bench for mem_arbiter plus a reset-mid-grant case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_rw, mem_ready;
    logic [DW-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]    dm_select;
    logic [DW-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]    mem_select;
    logic          if_ready, dm_ready, mem_access, mem_rw, if_stall, mem_stall, bus_err;

    mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_select(dm_select), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_access(mem_access), .mem_rw(mem_rw), .mem_select(mem_select),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        rw;
        logic [31:0] rdata;
        logic        err;
        int          glen;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    // The memory model answers after a latency taken from the low address bits.
    function automatic int lat_of(input logic [31:0] a);
        return int'(a[2:0]);
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic txn_t make_txn(input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] s, input logic w);
        txn_t t;
        t.addr = a; t.wdata = wd; t.sel = s; t.rw = w;
        if (lat_of(a) < TMO) begin
            t.rdata = data_of(a); t.err = 1'b0; t.glen = lat_of(a) + 1;
        end else begin
            t.rdata = 32'd0; t.err = 1'b1; t.glen = TMO;
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic note_fail(input string name, input int detail);
        checks++;
        $display("FAIL %s: got %0d expected event", name, detail);
    endtask

    task automatic wait_ready(input bit dside);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(dside ? dm_ready : if_ready) && n < 60);
        if (n >= 60) note_fail(dside ? "dm_ready_timeout" : "if_ready_timeout", n);
    endtask

    task automatic run_if(input int n);
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, 2);
            if (gap > 0) begin
                if_req = 1'b0;
                repeat (gap) begin @(posedge clk); #2; end
            end
            if_addr = $urandom;
            if_req  = 1'b1;
            iq.push_back(make_txn(if_addr, 32'd0, 4'hF, 1'b0));
            wait_ready(1'b0);
        end
        if_req = 1'b0;
    endtask

    task automatic run_dm(input int n);
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, 2);
            if (gap > 0) begin
                dm_req = 1'b0;
                repeat (gap) begin @(posedge clk); #2; end
            end
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            dm_select = 4'($urandom_range(0, 15));
            dm_rw     = 1'($urandom_range(0, 1));
            dm_req    = 1'b1;
            dq.push_back(make_txn(dm_addr, dm_wdata, dm_select, dm_rw));
            wait_ready(1'b1);
        end
        dm_req = 1'b0;
    endtask

    // Memory responder: also throws spurious mem_ready pulses while nothing is granted.
    initial begin
        int   gk;
        logic pa;
        gk = 0; pa = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_access) begin
                gk        = pa ? gk + 1 : 0;
                mem_ready = (gk == lat_of(mem_addr));
                mem_rdata = mem_ready ? data_of(mem_addr) : $urandom;
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            pa = mem_access;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic pi, pd, pacc;
        bit   side_d, last_d;
        int   glen;
        txn_t t;
        pi = 1'b0; pd = 1'b0; pacc = 1'b0; side_d = 1'b0; last_d = 1'b0; glen = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk1("if_stall", if_stall, if_req & ~if_ready);
                chk1("mem_stall", mem_stall, dm_req & ~dm_ready);
                if (mem_access && !pacc) begin
                    if (!pi && !pd) note_fail("grant_without_request", 0);
                    side_d = (pi && pd) ? !last_d : pd;
                    last_d = side_d;
                    glen   = 0;
                end
                if (mem_access) begin
                    glen++;
                    if (side_d ? (dq.size() == 0) : (iq.size() == 0)) begin
                        note_fail("grant_with_empty_queue", glen);
                    end else begin
                        t = side_d ? dq[0] : iq[0];
                        chk("mem_addr", mem_addr, t.addr);
                        chk("mem_wdata", mem_wdata, t.wdata);
                        chk("mem_select", {28'd0, mem_select}, {28'd0, t.sel});
                        chk1("mem_rw", mem_rw, t.rw);
                    end
                end
                if (bus_err) chk1("bus_err_has_ready", if_ready | dm_ready, 1'b1);
                if (if_ready) begin
                    chk1("if_ready_mem_access", mem_access, 1'b0);
                    chk1("dual_ready", dm_ready, 1'b0);
                    if (side_d || iq.size() == 0 || !pacc) begin
                        note_fail("if_ready_unexpected", iq.size());
                    end else begin
                        t = iq.pop_front();
                        chk("if_rdata", if_rdata, t.rdata);
                        chk1("if_bus_err", bus_err, t.err);
                        chk("if_grant_cycles", 32'(glen), 32'(t.glen));
                    end
                end
                if (dm_ready) begin
                    chk1("dm_ready_mem_access", mem_access, 1'b0);
                    if (!side_d || dq.size() == 0 || !pacc) begin
                        note_fail("dm_ready_unexpected", dq.size());
                    end else begin
                        t = dq.pop_front();
                        chk("dm_rdata", dm_rdata, t.rdata);
                        chk1("dm_bus_err", bus_err, t.err);
                        chk("dm_grant_cycles", 32'(glen), 32'(t.glen));
                    end
                end
            end
            pi = if_req; pd = dm_req; pacc = mem_access;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_rw = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_select = 4'h0;
        repeat (3) @(posedge clk);
        #2;
        chk1("rst_mem_access", mem_access, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_dm_ready", dm_ready, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk1("rst_mem_rw", mem_rw, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_select", {28'd0, mem_select}, 32'd0);

        rst = 1'b0;
        mon_en = 1'b1;
        fork
            run_if(40);
            run_dm(40);
        join
        repeat (4) begin @(posedge clk); #2; end
        chk("if_queue_drained", 32'(iq.size()), 32'd0);
        chk("dm_queue_drained", 32'(dq.size()), 32'd0);
        mon_en = 1'b0;

        // Reset during the second cycle of a data grant that would otherwise time out.
        dm_addr = 32'h0000_0107; dm_wdata = 32'd0; dm_select = 4'hF; dm_rw = 1'b0;
        dm_req  = 1'b1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!mem_access && n < 10);
        if (n >= 10) note_fail("directed_grant_timeout", n);
        @(posedge clk); #2;
        chk1("g2_mem_access", mem_access, 1'b1);
        chk1("g2_no_ready", dm_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #2;
        chk1("post_rst_mem_access", mem_access, 1'b0);
        chk1("post_rst_dm_ready", dm_ready, 1'b0);
        chk1("post_rst_bus_err", bus_err, 1'b0);
        chk("post_rst_dm_rdata", dm_rdata, 32'd0);
        chk("post_rst_if_rdata", if_rdata, 32'd0);

        rst = 1'b0;
        if_addr = 32'h0000_0040;
        dm_addr = 32'h0000_0200; dm_wdata = 32'h0000_1234; dm_rw = 1'b1; dm_select = 4'b0011;
        if_req  = 1'b1;
        @(posedge clk); #2;
        chk1("conflict_mem_access", mem_access, 1'b1);
        chk("conflict_grants_data", mem_addr, 32'h0000_0200);
        chk1("conflict_mem_rw", mem_rw, 1'b1);
        chk("conflict_mem_select", {28'd0, mem_select}, 32'd3);
        wait_ready(1'b1);
        chk("conflict_dm_rdata", dm_rdata, data_of(32'h0000_0200));
        dm_req = 1'b0;
        wait_ready(1'b0);
        chk("fetch_if_rdata", if_rdata, data_of(32'h0000_0040));
        if_req = 1'b0;
        @(posedge clk); #2;
        chk1("final_if_ready_low", if_ready, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all address and data buses.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles a grant waits for mem_ready before abort (range 1..255).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 if_req  input  1  instruction-fetch request, held until if_ready.
REQ-007 if_addr  input  DATA_WIDTH  fetch address.
REQ-008 if_rdata  output  DATA_WIDTH  fetched instruction, valid while if_ready=1.
REQ-009 if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 dm_req  input  1  data-access request, held until dm_ready.
REQ-011 dm_rw  input  1  1=write, 0=read.
REQ-012 dm_select  input  4  byte-lane enables.
REQ-013 dm_addr, dm_wdata  input  DATA_WIDTH each  data address and write data.
REQ-014 dm_rdata  output  DATA_WIDTH  read data, valid while dm_ready=1.
REQ-015 dm_ready  output  1  one-cycle data completion pulse.
REQ-016 mem_access, mem_rw  output  1 each  shared-memory strobe and direction.
REQ-017 mem_select  output  4; mem_addr, mem_wdata  output  DATA_WIDTH  latched transaction fields.
REQ-018 mem_rdata  input  DATA_WIDTH; mem_ready  input  1  memory completion.
REQ-019 if_stall, mem_stall  output  1 each  pipeline stall requests for fetch and memory stages.
REQ-020 bus_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states SHALL be IDLE, GRANT_I and GRANT_D, all state and outputs registered except the stalls.
REQ-022 In IDLE, dm_req only -> GRANT_D; if_req only -> GRANT_I; neither -> stay IDLE.
REQ-023 On conflict (both requests set in IDLE), the grant SHALL go to the side not granted last, using a last_grant bit that resets to "instruction", so the first conflict after reset grants data.
REQ-024 On entering a GRANT state, the address, wdata, select and rw of the winner SHALL be latched; for GRANT_I, mem_rw=0 and mem_select=4'hF.
REQ-025 mem_access SHALL be 1 in every cycle spent in GRANT_I or GRANT_D, and 0 in IDLE.
REQ-026 In a GRANT state, mem_ready=1 SHALL latch mem_rdata into the winner's rdata register, pulse the winner's ready in the next cycle, update last_grant, and return to IDLE.
REQ-027 Minimum latency: request in cycle N, mem_access in N+1, mem_ready in N+1, ready pulse in N+2.
REQ-028 A new grant SHALL be possible in the cycle of the previous ready pulse, so back-to-back transactions cost 2 cycles each.
REQ-029 An 8-bit wait counter SHALL clear on grant and increment each GRANT cycle without mem_ready.
REQ-030 When the counter reaches TIMEOUT, the block SHALL abort: return to IDLE, pulse bus_err and the winner's ready, and force that rdata to 0.
REQ-031 If the request is dropped while granted, the transaction SHALL still complete and the ready pulse SHALL still be issued.
REQ-032 mem_ready arriving in IDLE SHALL be ignored.
REQ-033 if_stall SHALL equal if_req & ~if_ready, and mem_stall SHALL equal dm_req & ~dm_ready (combinational).
REQ-034 rdata registers SHALL hold their value between pulses.

Reset
REQ-035 A clock edge with rst=1 SHALL force state IDLE, last_grant=instruction, counter=0, and all registered outputs and rdata to 0, including mid-transaction.
REQ-036 A transaction in flight at reset SHALL be dropped with no ready pulse, and mem_access SHALL be 0 in the cycle after the reset edge.

Verification
REQ-037 Single fetch: if_req=1, if_addr=0x40, mem_ready same cycle as grant, mem_rdata=0x2108000A -> mem_addr=0x40, if_ready pulses 2 cycles after request with if_rdata=0x2108000A.
REQ-038 Conflict: if_req=dm_req=1 held from reset -> order is D, I, D, I, with each ready a single pulse.
REQ-039 Write: dm_rw=1, dm_select=4'b0011, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_* fields stable for 4 cycles, then dm_ready pulse, then mem_access=0.
REQ-040 Timeout: TIMEOUT=4, mem_ready never asserted -> after 4 GRANT cycles, bus_err and dm_ready pulse together with dm_rdata=0.
REQ-041 Reset mid-grant: rst=1 during the 2nd GRANT_D cycle -> no dm_ready pulse, mem_access=0 on the next cycle, and the first post-reset conflict grants data.
REQ-042 Stall check: dm_req=1 held for 5 cycles before completion -> mem_stall=1 in every cycle except the dm_ready cycle.
